// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_pkg
//  Description : Pattern mode encodings and the 8-colour bar palette.
//  Revision    : 1.0  initial release
// ============================================================================
package lcd_pkg;

    typedef enum logic [1:0] {
        MODE_HBAR  = 2'd0,
        MODE_VBAR  = 2'd1,
        MODE_GRAY  = 2'd2,
        MODE_CHECK = 2'd3
    } lcd_mode_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb8_t;

    localparam rgb8_t c_pal_red     = 24'hFF0000;
    localparam rgb8_t c_pal_green   = 24'h00FF00;
    localparam rgb8_t c_pal_blue    = 24'h0000FF;
    localparam rgb8_t c_pal_white   = 24'hFFFFFF;
    localparam rgb8_t c_pal_black   = 24'h000000;
    localparam rgb8_t c_pal_yellow  = 24'hFFFF00;
    localparam rgb8_t c_pal_magenta = 24'hFF00FF;
    localparam rgb8_t c_pal_cyan    = 24'h00FFFF;

    // Entries are full-scale, so taking channel MSBs narrows them without loss.
    function automatic rgb8_t palette_lookup(input logic [2:0] idx);
        rgb8_t v;
        case (idx)
            3'd0:    v = c_pal_red;
            3'd1:    v = c_pal_green;
            3'd2:    v = c_pal_blue;
            3'd3:    v = c_pal_white;
            3'd4:    v = c_pal_black;
            3'd5:    v = c_pal_yellow;
            3'd6:    v = c_pal_magenta;
            default: v = c_pal_cyan;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_seg_counter.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_seg_counter
//  Description : Segment counter with saturating segment index.
//  Revision    : 1.0  initial release
// ============================================================================
module lcd_seg_counter #(
    parameter int SEG_LEN = 100,
    parameter int SEG_CNT = 8,
    parameter int IDX_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_advance,
    output logic [IDX_W-1:0] o_idx
);
    import lcd_pkg::*;

    localparam int                 c_seg_w    = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1;
    localparam logic [c_seg_w-1:0] c_seg_last = c_seg_w'(SEG_LEN - 1);
    localparam logic [IDX_W-1:0]   c_idx_last = IDX_W'(SEG_CNT - 1);

    logic [c_seg_w-1:0] r_seg;
    logic [IDX_W-1:0]   r_idx;

    // The registered state always describes the step just applied.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_seg <= '0;
            r_idx <= '0;
        end else if (i_advance) begin
            if (r_seg == c_seg_last) begin
                r_seg <= '0;
                if (r_idx != c_idx_last) begin
                    r_idx <= r_idx + 1'b1;
                end
            end else begin
                r_seg <= r_seg + 1'b1;
            end
        end
    end

    assign o_idx = r_idx;

endmodule
`default_nettype wire

// File: rtl/lcd_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_pattern_gen
//  Description : LCD test pattern generator (bars, gray ramp, checkerboard).
//  Revision    : 1.0  initial release
// ============================================================================
module lcd_pattern_gen #(
    parameter int H_DISP     = 800,
    parameter int V_DISP     = 480,
    parameter int NUM_BARS   = 8,
    parameter int COLOR_W    = 8,
    parameter int SCROLL_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lcd_de_in,
    input  logic [11:0]          lcd_xpos,
    input  logic [11:0]          lcd_ypos,
    input  logic [1:0]           mode_i,
    input  logic                 scroll_en,
    output logic                 lcd_de_out,
    output logic [3*COLOR_W-1:0] lcd_data,
    output logic                 frame_start
);
    import lcd_pkg::*;

    localparam int                 c_bar_w    = $clog2(NUM_BARS);
    localparam int                 c_sum_w    = c_bar_w + 1;
    localparam int                 c_fc_w     = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [c_fc_w-1:0]  c_fc_last  = c_fc_w'(SCROLL_DIV - 1);
    localparam logic [c_bar_w-1:0] c_bar_last = c_bar_w'(NUM_BARS - 1);
    localparam logic [c_sum_w-1:0] c_num_bars = c_sum_w'(NUM_BARS);
    localparam logic [11:0]        c_y_half   = 12'(V_DISP / 2);

    logic               w_boundary;
    logic               w_col_clear;
    logic               w_col_adv;
    logic               w_row_adv;
    logic               w_scroll_shadow;
    logic [c_bar_w-1:0] w_col_idx;
    logic [c_bar_w-1:0] w_row_idx;

    logic               r_armed;
    lcd_mode_e          r_mode;
    logic               r_scroll_en;
    logic [c_fc_w-1:0]  r_fcnt;
    logic [c_bar_w-1:0] r_scroll_off;
    logic [c_bar_w-1:0] r_disp_off;
    logic               r_de1;
    logic               r_fs1;
    logic               r_y_upper;
    logic [COLOR_W-1:0] r_x_lo;
    logic [COLOR_W-1:0] r_y_lo;

    logic [c_bar_w-1:0]   w_bar_sel;
    logic [c_sum_w-1:0]   w_bar_sum;
    logic [c_sum_w-1:0]   w_bar_disp;
    rgb8_t                w_pal;
    logic [COLOR_W-1:0]   w_gray;
    logic                 w_check_white;
    logic [3*COLOR_W-1:0] w_pixel;

    logic                 r_de2;
    logic                 r_fs2;
    logic [3*COLOR_W-1:0] r_data2;

    assign w_boundary      = lcd_de_in && (lcd_xpos == 12'd0) && (lcd_ypos == 12'd0);
    assign w_col_clear     = lcd_de_in && (lcd_xpos == 12'd0);
    assign w_col_adv       = lcd_de_in && (lcd_xpos != 12'd0);
    assign w_row_adv       = lcd_de_in && (lcd_xpos == 12'd0) && (lcd_ypos != 12'd0);
    assign w_scroll_shadow = w_boundary ? scroll_en : r_scroll_en;

    lcd_seg_counter #(
        .SEG_LEN (H_DISP / NUM_BARS),
        .SEG_CNT (NUM_BARS),
        .IDX_W   (c_bar_w)
    ) u_col_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_col_clear),
        .i_advance (w_col_adv),
        .o_idx     (w_col_idx)
    );

    lcd_seg_counter #(
        .SEG_LEN (V_DISP / NUM_BARS),
        .SEG_CNT (NUM_BARS),
        .IDX_W   (c_bar_w)
    ) u_row_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_boundary),
        .i_advance (w_row_adv),
        .o_idx     (w_row_idx)
    );

    // Stage 1: frame-level shadows, scroll bookkeeping and coordinate capture.
    // A frame only displays the offset in force before its own boundary step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed      <= 1'b0;
            r_mode       <= MODE_HBAR;
            r_scroll_en  <= 1'b0;
            r_fcnt       <= '0;
            r_scroll_off <= '0;
            r_disp_off   <= '0;
            r_de1        <= 1'b0;
            r_fs1        <= 1'b0;
            r_y_upper    <= 1'b0;
            r_x_lo       <= '0;
            r_y_lo       <= '0;
        end else begin
            r_de1     <= lcd_de_in && (r_armed || w_boundary);
            r_fs1     <= w_boundary;
            r_y_upper <= (lcd_ypos < c_y_half);
            r_x_lo    <= lcd_xpos[COLOR_W-1:0];
            r_y_lo    <= lcd_ypos[COLOR_W-1:0];
            if (w_boundary) begin
                r_armed     <= 1'b1;
                r_mode      <= lcd_mode_e'(mode_i);
                r_scroll_en <= scroll_en;
                r_disp_off  <= r_scroll_off;
                if (w_scroll_shadow) begin
                    if (r_fcnt == c_fc_last) begin
                        r_fcnt       <= '0;
                        r_scroll_off <= (r_scroll_off == c_bar_last) ? '0 : r_scroll_off + 1'b1;
                    end else begin
                        r_fcnt <= r_fcnt + 1'b1;
                    end
                end
            end
        end
    end

    assign w_bar_sel     = (r_mode == MODE_HBAR) ? w_row_idx : w_col_idx;
    assign w_bar_sum     = {1'b0, w_bar_sel} + {1'b0, r_disp_off};
    assign w_bar_disp    = (w_bar_sum >= c_num_bars) ? (w_bar_sum - c_num_bars) : w_bar_sum;
    assign w_check_white = ~(w_col_idx[0] ^ w_row_idx[0] ^ r_disp_off[0]);

    always_comb begin
        w_pal   = palette_lookup(3'(w_bar_disp));
        w_gray  = r_y_upper ? r_x_lo : r_y_lo;
        w_pixel = '0;
        case (r_mode)
            MODE_HBAR, MODE_VBAR: w_pixel = {w_pal.r[7 -: COLOR_W],
                                             w_pal.g[7 -: COLOR_W],
                                             w_pal.b[7 -: COLOR_W]};
            MODE_GRAY:            w_pixel = {3{w_gray}};
            MODE_CHECK:           w_pixel = w_check_white ? '1 : '0;
            default:              w_pixel = '0;
        endcase
    end

    // Stage 2: output register; data is forced to zero outside active video.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_de2   <= 1'b0;
            r_fs2   <= 1'b0;
            r_data2 <= '0;
        end else begin
            r_de2   <= r_de1;
            r_fs2   <= r_fs1 && r_de1;
            r_data2 <= r_de1 ? w_pixel : '0;
        end
    end

    assign lcd_de_out  = r_de2;
    assign frame_start = r_fs2;
    assign lcd_data    = r_data2;

endmodule
`default_nettype wire
